datapath_param: RTL and testbench



---
 rtl/datapath_param.sv | 206 ++++++++++++++++++++
 tb/tb_datapath_param.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_param.sv
// Parametrised datapath: register file, ALU and LIFO stack behind a valid/ready
// command port, sequenced IDLE -> EXEC -> WB with a registered one-cycle response.
module datapath_param #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_op,
    input  logic [3:0]                   cmd_alu,
    input  logic [$clog2(NREGS)-1:0]     cmd_rd,
    input  logic [$clog2(NREGS)-1:0]     cmd_rs1,
    input  logic [$clog2(NREGS)-1:0]     cmd_rs2,
    input  logic [WIDTH-1:0]             cmd_imm,
    output logic                         rsp_valid,
    output logic [WIDTH-1:0]             rsp_data,
    output logic                         rsp_err,
    output logic                         flag_carry,
    output logic                         flag_zero,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic [$clog2(DEPTH+1)-1:0]   stack_count,
    output logic [WIDTH-1:0]             dbg_a,
    output logic [WIDTH-1:0]             dbg_b
);
    localparam int RW = $clog2(NREGS);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ALU  = 3'd2;
    localparam logic [2:0] OP_PUSH = 3'd3;
    localparam logic [2:0] OP_POP  = 3'd4;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    state_t state_reg, state_next;

    logic [WIDTH-1:0] regs      [NREGS];
    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [CW-1:0]    count_reg;

    logic [2:0]       op_reg;
    logic [3:0]       alu_reg;
    logic [RW-1:0]    rd_reg, rs1_reg, rs2_reg;
    logic [WIDTH-1:0] imm_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg, err_reg;
    logic             flag_carry_reg, flag_zero_reg;
    logic             rsp_valid_reg, rsp_err_reg;
    logic [WIDTH-1:0] rsp_data_reg;

    logic             accept;
    logic [WIDTH-1:0] op_a, op_b, stack_top;
    logic [CW-1:0]    top_count;
    logic [WIDTH:0]   alu_wide;
    logic             alu_bad;
    logic [WIDTH-1:0] exec_result;
    logic             exec_carry, exec_err;

    assign cmd_ready = (state_reg == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign op_a      = regs[rs1_reg];
    assign op_b      = regs[rs2_reg];
    assign top_count = count_reg - CW'(1);
    assign stack_top = stack_mem[top_count[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bit WIDTH of alu_wide carries the carry/borrow out of each function.
    always_comb begin
        alu_wide = '0;
        alu_bad  = 1'b0;
        case (alu_reg)
            4'd0:    alu_wide = {1'b0, op_a} + {1'b0, op_b};
            4'd1:    alu_wide = {1'b0, op_a} - {1'b0, op_b};
            4'd2:    alu_wide = {1'b0, op_a & op_b};
            4'd3:    alu_wide = {1'b0, op_a | op_b};
            4'd4:    alu_wide = {1'b0, op_a ^ op_b};
            4'd5:    alu_wide = {1'b0, ~op_a};
            4'd6:    alu_wide = {op_a, 1'b0};
            4'd7:    alu_wide = {op_a[0], 1'b0, op_a[WIDTH-1:1]};
            4'd8:    alu_wide = {1'b0, op_a};
            4'd9:    alu_wide = {1'b0, op_a} + (WIDTH+1)'(1);
            4'd10:   alu_wide = {1'b0, op_a} - (WIDTH+1)'(1);
            default: alu_bad  = 1'b1;
        endcase
    end

    always_comb begin
        exec_result = '0;
        exec_carry  = 1'b0;
        exec_err    = 1'b0;
        case (op_reg)
            OP_NOP:  exec_result = '0;
            OP_LOAD: exec_result = imm_reg;
            OP_ALU: begin
                exec_err    = alu_bad;
                exec_result = alu_wide[WIDTH-1:0];
                exec_carry  = alu_wide[WIDTH];
            end
            OP_PUSH: begin
                exec_err    = (count_reg == FULL_COUNT);
                exec_result = op_a;
            end
            OP_POP: begin
                exec_err    = (count_reg == '0);
                exec_result = stack_top;
            end
            default: exec_err = 1'b1;
        endcase
        if (exec_err) exec_result = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg     <= OP_NOP;
            alu_reg    <= '0;
            rd_reg     <= '0;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            imm_reg    <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else if (accept) begin
            op_reg  <= cmd_op;
            alu_reg <= cmd_alu;
            rd_reg  <= cmd_rd;
            rs1_reg <= cmd_rs1;
            rs2_reg <= cmd_rs2;
            imm_reg <= cmd_imm;
        end else if (state_reg == EXEC) begin
            result_reg <= exec_result;
            carry_reg  <= exec_carry;
            err_reg    <= exec_err;
        end
    end

    // All architectural state commits only in WB, and only for a command without error.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            for (int i = 0; i < DEPTH; i++) stack_mem[i] <= '0;
            count_reg      <= '0;
            flag_carry_reg <= 1'b0;
            flag_zero_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_data_reg   <= '0;
        end else begin
            rsp_valid_reg <= (state_reg == WB);
            if (state_reg == WB) begin
                rsp_err_reg  <= err_reg;
                rsp_data_reg <= result_reg;
                if (!err_reg) begin
                    case (op_reg)
                        OP_LOAD: regs[rd_reg] <= result_reg;
                        OP_ALU: begin
                            regs[rd_reg]   <= result_reg;
                            flag_carry_reg <= carry_reg;
                            flag_zero_reg  <= (result_reg == '0);
                        end
                        OP_PUSH: begin
                            stack_mem[count_reg[AW-1:0]] <= result_reg;
                            count_reg <= count_reg + CW'(1);
                        end
                        OP_POP: begin
                            regs[rd_reg] <= result_reg;
                            count_reg    <= count_reg - CW'(1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_data    = rsp_data_reg;
    assign flag_carry  = flag_carry_reg;
    assign flag_zero   = flag_zero_reg;
    assign stack_count = count_reg;
    assign stack_full  = (count_reg == FULL_COUNT);
    assign stack_empty = (count_reg == '0);
    assign dbg_a       = regs[cmd_rs1];
    assign dbg_b       = regs[cmd_rs2];
endmodule

// File: tb/tb_datapath_param.sv
// Bench for datapath_param: directed scenarios plus random commands, checked
// against an arithmetic model of registers, stack (queue) and flags.
`timescale 1ns/1ps
module tb_datapath_param;
    localparam int WIDTH = 8;
    localparam int NREGS = 4;
    localparam int DEPTH = 8;
    localparam int RW = $clog2(NREGS);
    localparam int CW = $clog2(DEPTH + 1);
    localparam longint MASK = (64'sd1 <<< WIDTH) - 1;

    logic clk = 1'b0;
    logic rst, cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_alu;
    logic [RW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [WIDTH-1:0] cmd_imm, rsp_data, dbg_a, dbg_b;
    logic rsp_valid, rsp_err, flag_carry, flag_zero, stack_full, stack_empty;
    logic [CW-1:0] stack_count;

    datapath_param #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_alu(cmd_alu), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1),
        .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .flag_carry(flag_carry),
        .flag_zero(flag_zero), .stack_full(stack_full), .stack_empty(stack_empty),
        .stack_count(stack_count), .dbg_a(dbg_a), .dbg_b(dbg_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    longint m_regs [NREGS];
    longint m_stack [$];
    bit     m_carry, m_zero;

    logic [WIDTH-1:0] last_data;
    logic             last_err;
    int               last_acc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
        m_stack.delete();
        m_carry = 0;
        m_zero  = 0;
    endtask

    task automatic check_regs();
        for (int i = 0; i < NREGS; i++) begin
            cmd_rs1 = RW'(i);
            cmd_rs2 = RW'(NREGS - 1 - i);
            #0.5;
            check_val($sformatf("dbg_a_r%0d", i), 64'(dbg_a), 64'(m_regs[i]));
            check_val($sformatf("dbg_b_r%0d", NREGS - 1 - i), 64'(dbg_b), 64'(m_regs[NREGS - 1 - i]));
        end
    endtask

    task automatic check_status();
        check_val("flag_carry", 64'(flag_carry), 64'(m_carry));
        check_val("flag_zero", 64'(flag_zero), 64'(m_zero));
        check_val("stack_count", 64'(stack_count), 64'(m_stack.size()));
        check_val("stack_full", 64'(stack_full), 64'(m_stack.size() == DEPTH));
        check_val("stack_empty", 64'(stack_empty), 64'(m_stack.size() == 0));
    endtask

    // Issues one command (called between edges), predicts its effect, and checks
    // the two-cycle busy window and the response at edge k+2.
    task automatic run_cmd(input int op, input int alu, input int rd, input int rs1,
                           input int rs2, input longint imm);
        int n;
        int old_count;
        longint a, b, r, d;
        bit c, e;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check_val("ready_timeout", 64'(cmd_ready), 64'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op  = 3'(op);
        cmd_alu = 4'(alu);
        cmd_rd  = RW'(rd);
        cmd_rs1 = RW'(rs1);
        cmd_rs2 = RW'(rs2);
        cmd_imm = WIDTH'(imm);

        old_count = m_stack.size();
        a = m_regs[rs1];
        b = m_regs[rs2];
        e = 0;
        d = 0;
        r = 0;
        c = 0;
        case (op)
            0: d = 0;
            1: begin d = imm & MASK; m_regs[rd] = d; end
            2: begin
                if (alu > 10) e = 1;
                else begin
                    case (alu)
                        0:  begin r = (a + b) & MASK; c = (a + b) > MASK; end
                        1:  begin r = (a - b) & MASK; c = a < b; end
                        2:  r = a & b;
                        3:  r = a | b;
                        4:  r = a ^ b;
                        5:  r = MASK - a;
                        6:  begin r = (a * 2) & MASK; c = a >= (MASK + 1) / 2; end
                        7:  begin r = a / 2; c = (a % 2) == 1; end
                        8:  r = a;
                        9:  begin r = (a + 1) & MASK; c = (a == MASK); end
                        default: begin r = (a - 1) & MASK; c = (a == 0); end
                    endcase
                    m_regs[rd] = r;
                    m_carry = c;
                    m_zero  = (r == 0);
                    d = r;
                end
            end
            3: begin
                if (m_stack.size() >= DEPTH) e = 1;
                else begin m_stack.push_back(a); d = a; end
            end
            4: begin
                if (m_stack.size() == 0) e = 1;
                else begin d = m_stack.pop_back(); m_regs[rd] = d; end
            end
            default: e = 1;
        endcase

        @(posedge clk);
        @(negedge clk);
        last_acc = cyc;
        check_val("exec_ready", 64'(cmd_ready), 64'd0);
        check_val("exec_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("exec_count", 64'(stack_count), 64'(old_count));
        // fields outside the accept cycle must be ignored
        cmd_op  = 3'($urandom);
        cmd_alu = 4'($urandom);
        cmd_rd  = RW'($urandom);
        cmd_imm = WIDTH'($urandom);
        @(posedge clk);
        @(negedge clk);
        check_val("wb_ready", 64'(cmd_ready), 64'd0);
        check_val("wb_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("rsp_valid", 64'(rsp_valid), 64'd1);
        check_val("rsp_ready", 64'(cmd_ready), 64'd1);
        check_val("rsp_err", 64'(rsp_err), 64'(e));
        check_val("rsp_data", 64'(rsp_data), 64'(d));
        last_data = rsp_data;
        last_err  = rsp_err;
        check_status();
        cmd_valid = 1'b0;
        $display("cmd op=%0d alu=%0d rd=%0d rs1=%0d rs2=%0d imm=%02h -> data=%02h err=%0b count=%0d",
                 op, alu, rd, rs1, rs2, imm & MASK, rsp_data, rsp_err, stack_count);
    endtask

    initial begin
        int prev_acc;
        int op, alu;
        longint vals [DEPTH];

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_alu = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
        model_reset();
        @(negedge clk);
        check_val("ready_in_reset", 64'(cmd_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #0.5;
        check_val("reset_ready", 64'(cmd_ready), 64'd1);
        check_val("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("reset_rsp_err", 64'(rsp_err), 64'd0);
        check_val("reset_rsp_data", 64'(rsp_data), 64'd0);
        check_status();
        check_regs();

        // ADD with carry-out
        run_cmd(1, 0, 1, 0, 0, 'hF0);
        run_cmd(1, 0, 2, 0, 0, 'h20);
        run_cmd(2, 0, 3, 1, 2, 0);
        check_val("add_result", 64'(last_data), 64'h10);
        check_val("add_carry", 64'(flag_carry), 64'd1);
        check_val("add_zero", 64'(flag_zero), 64'd0);
        check_regs();

        // SUB to zero, SHR shifting out a one
        run_cmd(1, 0, 1, 0, 0, 'h20);
        run_cmd(2, 1, 3, 1, 2, 0);
        check_val("sub_zero", 64'(flag_zero), 64'd1);
        check_val("sub_borrow", 64'(flag_carry), 64'd0);
        run_cmd(1, 0, 1, 0, 0, 'h01);
        run_cmd(2, 7, 3, 1, 0, 0);
        check_val("shr_result", 64'(last_data), 64'h00);
        check_val("shr_carry", 64'(flag_carry), 64'd1);
        check_regs();

        // Fill the stack, overflow, drain in reverse order, underflow
        for (int i = 0; i < DEPTH; i++) begin
            vals[i] = (i * 37 + 9) & MASK;
            run_cmd(1, 0, 0, 0, 0, vals[i]);
            run_cmd(3, 0, 0, 0, 0, 0);
        end
        check_val("stack_full_at_depth", 64'(stack_full), 64'd1);
        check_val("stack_count_at_depth", 64'(stack_count), 64'(DEPTH));
        run_cmd(1, 0, 0, 0, 0, 'hAB);
        run_cmd(3, 0, 0, 0, 0, 0);
        check_val("push_full_err", 64'(last_err), 64'd1);
        check_val("push_full_count", 64'(stack_count), 64'(DEPTH));
        for (int i = DEPTH - 1; i >= 0; i--) begin
            run_cmd(4, 0, 1, 0, 0, 0);
            check_val($sformatf("pop_%0d", i), 64'(last_data), 64'(vals[i]));
        end
        run_cmd(1, 0, 1, 0, 0, 'h3C);
        run_cmd(4, 0, 1, 0, 0, 0);
        check_val("pop_empty_err", 64'(last_err), 64'd1);
        check_regs();

        // Illegal opcode and illegal ALU function
        run_cmd(6, 0, 2, 0, 1, 'hFF);
        check_val("illegal_op_err", 64'(last_err), 64'd1);
        run_cmd(2, 12, 2, 0, 1, 0);
        check_val("illegal_alu_err", 64'(last_err), 64'd1);
        check_regs();

        // Reset while a LOAD is in EXEC
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_rd = RW'(1); cmd_imm = WIDTH'('h55);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b0;
        #0.5;
        check_val("rst_ready_low", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("rst_no_rsp", 64'(rsp_valid), 64'd0);
        check_val("rst_ready_low2", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #0.5;
        check_val("rst_ready_back", 64'(cmd_ready), 64'd1);
        model_reset();
        check_status();
        check_regs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_rsp_quiet", 64'(rsp_valid), 64'd0);
        end

        // Back-to-back with cmd_valid held high
        run_cmd(1, 0, 0, 0, 0, 'h07);
        prev_acc = last_acc;
        run_cmd(2, 0, 0, 0, 0, 0);
        check_val("b2b_spacing", 64'(last_acc - prev_acc), 64'd3);
        check_val("b2b_result", 64'(last_data), 64'h0E);
        check_regs();

        // Random commands
        for (int t = 0; t < 200; t++) begin
            op = $urandom_range(0, 7);
            if (op >= 5 && $urandom_range(0, 3) != 0) op = $urandom_range(1, 4);
            alu = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 10);
            run_cmd(op, alu, $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
                    $urandom_range(0, NREGS - 1), longint'($urandom) & MASK);
            check_regs();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
